// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, FSM state
// codes and the select encodings seen by the datapath muxes and ALU.
package cpu_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   typedef enum logic [3:0] {
      S_INIT    = 4'd0,
      S_IF      = 4'd1,
      S_ID      = 4'd2,
      S_EXE_R   = 4'd3,
      S_EXE_I   = 4'd4,
      S_EXE_MEM = 4'd5,
      S_EXE_BR  = 4'd6,
      S_EXE_J   = 4'd7,
      S_MEM_RD  = 4'd8,
      S_MEM_WR  = 4'd9,
      S_WB_R    = 4'd10,
      S_WB_I    = 4'd11,
      S_WB_MEM  = 4'd12,
      S_HALT    = 4'd13
   } state_t;

   // ALU source-B mux select; codes 5..7 are never produced.
   localparam logic [2:0] SRCB_RT     = 3'd0;
   localparam logic [2:0] SRCB_FOUR   = 3'd1;
   localparam logic [2:0] SRCB_SEXT   = 3'd2;
   localparam logic [2:0] SRCB_ZEXT   = 3'd3;
   localparam logic [2:0] SRCB_BRANCH = 3'd4;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;
   localparam logic [1:0] ALUOP_OR    = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   function automatic logic is_known_op(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_ADDI, OP_ORI, OP_LW,
         OP_SW, OP_BEQ, OP_J, OP_HALT: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational output decode for the multicycle controller: maps the current
// state (plus opcode, zero and mem_ready where they matter) to datapath controls.
import cpu_ctrl_pkg::*;

module ctrl_decode (
   input  state_t      state,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        iord,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [2:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        illegal,
   output logic        halted
);

   always_comb begin
      pc_write   = 1'b0;
      pc_src     = PCSRC_ALU;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      alu_op     = ALUOP_ADD;
      illegal    = 1'b0;
      halted     = 1'b0;

      case (state)
         S_IF: begin
            // PC+4 and the IR load only commit once memory returns the word.
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_ID: begin
            alu_src_b = SRCB_BRANCH;
            illegal   = ~is_known_op(opcode);
         end
         S_EXE_R: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         S_EXE_I: begin
            alu_src_a = 1'b1;
            if (opcode == OP_ORI) begin
               alu_src_b = SRCB_ZEXT;
               alu_op    = ALUOP_OR;
            end else begin
               alu_src_b = SRCB_SEXT;
            end
         end
         S_EXE_MEM: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_SEXT;
         end
         S_EXE_BR: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_SUB;
            pc_src    = PCSRC_ALUOUT;
            pc_write  = zero;
         end
         S_EXE_J: begin
            pc_src   = PCSRC_JUMP;
            pc_write = 1'b1;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_WB_R: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_WB_I: begin
            reg_write = 1'b1;
         end
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: holds the state register and sequencing; all
// datapath controls come from ctrl_decode so they follow the state directly.
import cpu_ctrl_pkg::*;

module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [3:0]  state,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        iord,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [2:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        illegal,
   output logic        halted
);

   state_t state_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_INIT;
      end else begin
         case (state_reg)
            S_INIT:    state_reg <= S_IF;
            S_IF:      if (mem_ready) state_reg <= S_ID;
            S_ID: begin
               case (opcode)
                  OP_RTYPE:       state_reg <= S_EXE_R;
                  OP_ADDI, OP_ORI: state_reg <= S_EXE_I;
                  OP_LW, OP_SW:   state_reg <= S_EXE_MEM;
                  OP_BEQ:         state_reg <= S_EXE_BR;
                  OP_J:           state_reg <= S_EXE_J;
                  OP_HALT:        state_reg <= S_HALT;
                  default:        state_reg <= S_IF;  // illegal pulses in ID
               endcase
            end
            S_EXE_R:   state_reg <= S_WB_R;
            S_EXE_I:   state_reg <= S_WB_I;
            S_EXE_MEM: state_reg <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_EXE_BR:  state_reg <= S_IF;
            S_EXE_J:   state_reg <= S_IF;
            S_MEM_RD:  if (mem_ready) state_reg <= S_WB_MEM;
            S_MEM_WR:  if (mem_ready) state_reg <= S_IF;
            S_WB_R:    state_reg <= S_IF;
            S_WB_I:    state_reg <= S_IF;
            S_WB_MEM:  state_reg <= S_IF;
            S_HALT:    state_reg <= S_HALT;
            default:   state_reg <= S_INIT;
         endcase
      end
   end

   assign state = state_reg;

   ctrl_decode u_decode (
      .state      (state_reg),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .ir_write   (ir_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .iord       (iord),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .illegal    (illegal),
      .halted     (halted)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction reference model
// plans every cycle's inputs and expected outputs; a driver and monitor consume them.
module tb_multicycle_ctrl;

   localparam logic [5:0] RTYPE = 6'b000000, ADDI = 6'b001000, ORI = 6'b001101,
                          LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                          JMP = 6'b000010, HLT = 6'b111111;

   localparam logic [3:0] INIT = 0, IF = 1, ID = 2, EXE_R = 3, EXE_I = 4,
                          EXE_MEM = 5, EXE_BR = 6, EXE_J = 7, MEM_RD = 8,
                          MEM_WR = 9, WB_R = 10, WB_I = 11, WB_MEM = 12, HALT = 13;

   typedef struct packed {
      logic [3:0] state;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [2:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal;
      logic       halted;
   } outs_t;

   typedef struct packed {
      logic [5:0] op;
      logic       z;
      logic       mr;
   } stim_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;

   logic [3:0] state;
   logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write;
   logic       reg_dst, mem_to_reg, alu_src_a, illegal, halted;
   logic [1:0] pc_src, alu_op;
   logic [2:0] alu_src_b;

   int checks = 0;
   int failures = 0;

   stim_t stim_q[$];
   outs_t exp_q[$];

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .state(state), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
      .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal), .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic outs_t actual();
      return '{state, pc_write, pc_src, ir_write, mem_read, mem_write, iord,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               illegal, halted};
   endfunction

   function automatic logic legal(input logic [5:0] op);
      return op inside {RTYPE, ADDI, ORI, LW, SW, BEQ, JMP, HLT};
   endfunction

   // What the controller should present in a given state for given inputs.
   function automatic outs_t expect_out(input logic [3:0] st, input stim_t s);
      outs_t o = '0;
      o.state = st;
      case (st)
         IF:      begin o.mem_read = 1; o.alu_src_b = 1; o.ir_write = s.mr; o.pc_write = s.mr; end
         ID:      begin o.alu_src_b = 4; o.illegal = !legal(s.op); end
         EXE_R:   begin o.alu_src_a = 1; o.alu_op = 2; end
         EXE_I:   begin o.alu_src_a = 1; o.alu_src_b = (s.op == ORI) ? 3'd3 : 3'd2;
                        o.alu_op = (s.op == ORI) ? 2'd3 : 2'd0; end
         EXE_MEM: begin o.alu_src_a = 1; o.alu_src_b = 2; end
         EXE_BR:  begin o.alu_src_a = 1; o.alu_op = 1; o.pc_src = 1; o.pc_write = s.z; end
         EXE_J:   begin o.pc_src = 2; o.pc_write = 1; end
         MEM_RD:  begin o.mem_read = 1; o.iord = 1; end
         MEM_WR:  begin o.mem_write = 1; o.iord = 1; end
         WB_R:    begin o.reg_write = 1; o.reg_dst = 1; end
         WB_I:    begin o.reg_write = 1; end
         WB_MEM:  begin o.reg_write = 1; o.mem_to_reg = 1; end
         HALT:    begin o.halted = 1; end
         default: ;
      endcase
      return o;
   endfunction

   function automatic logic rbit();
      return ($urandom & 1) != 0;
   endfunction

   task automatic add(input logic [3:0] st, input logic [5:0] op, input logic z, input logic mr);
      stim_t s;
      s = '{op, z, mr};
      stim_q.push_back(s);
      exp_q.push_back(expect_out(st, s));
   endtask

   // One instruction: IF stalls, decode, then the opcode's phases. Inputs that
   // should not matter in a state are randomised to expose stray dependencies.
   task automatic instr(input logic [5:0] op, input logic z, input int ifs, input int ms);
      for (int i = 0; i < ifs; i++) add(IF, 6'($urandom), rbit(), 1'b0);
      add(IF, 6'($urandom), rbit(), 1'b1);
      add(ID, op, rbit(), rbit());
      case (op)
         RTYPE: begin add(EXE_R, op, rbit(), rbit()); add(WB_R, op, rbit(), rbit()); end
         ADDI, ORI: begin add(EXE_I, op, rbit(), rbit()); add(WB_I, op, rbit(), rbit()); end
         LW: begin
            add(EXE_MEM, op, rbit(), rbit());
            for (int i = 0; i < ms; i++) add(MEM_RD, op, rbit(), 1'b0);
            add(MEM_RD, op, rbit(), 1'b1);
            add(WB_MEM, op, rbit(), rbit());
         end
         SW: begin
            add(EXE_MEM, op, rbit(), rbit());
            for (int i = 0; i < ms; i++) add(MEM_WR, op, rbit(), 1'b0);
            add(MEM_WR, op, rbit(), 1'b1);
         end
         BEQ: add(EXE_BR, op, z, rbit());
         JMP: add(EXE_J, op, rbit(), rbit());
         HLT: for (int i = 0; i < 20; i++) add(HALT, op, rbit(), rbit());
         default: ;
      endcase
   endtask

   task automatic check(input string name, input outs_t act, input outs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
                  name, act.state, act, exp.state, exp);
      end
   endtask

   // Driver applies one cycle of inputs per falling edge; monitor pops the
   // expected response and samples 2 time units later, well clear of posedge.
   task automatic run_plan();
      int n;
      n = stim_q.size();
      fork
         begin
            stim_t s;
            for (int i = 0; i < n; i++) begin
               @(negedge clk);
               s = stim_q.pop_front();
               opcode = s.op; zero = s.z; mem_ready = s.mr;
            end
         end
         begin
            outs_t e;
            for (int i = 0; i < n; i++) begin
               @(negedge clk);
               #2;
               e = exp_q.pop_front();
               check($sformatf("cycle%0d", i), actual(), e);
            end
         end
      join
   endtask

   initial begin
      outs_t zeros;
      logic [5:0] op;
      int k;
      zeros = '0;

      repeat (2) @(negedge clk);
      #2 check("reset_state", actual(), zeros);

      @(posedge clk); #1 rst_n = 1'b1;
      add(INIT, 6'($urandom), rbit(), rbit());
      instr(RTYPE, 1'b0, 0, 0);
      instr(LW, 1'b0, 0, 2);
      instr(ORI, 1'b0, 0, 0);
      instr(ADDI, 1'b0, 1, 0);
      instr(BEQ, 1'b1, 0, 0);
      instr(BEQ, 1'b0, 0, 0);
      instr(SW, 1'b0, 0, 1);
      instr(JMP, 1'b0, 2, 0);
      instr(6'b111110, 1'b0, 0, 0);
      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 8);
         case (k)
            0: op = RTYPE; 1: op = ADDI; 2: op = ORI; 3: op = LW;
            4: op = SW;    5: op = BEQ;  6: op = JMP;
            default: begin
               do op = 6'($urandom); while (legal(op));
            end
         endcase
         instr(op, rbit(), $urandom_range(0, 2), $urandom_range(0, 2));
      end
      instr(HLT, 1'b0, 0, 0);
      run_plan();

      // Reset out of HALT returns to INIT immediately.
      #1 rst_n = 1'b0;
      #1 check("halt_reset", actual(), zeros);
      @(posedge clk); #1 rst_n = 1'b1;

      // Reset in the middle of a stalled store must drop mem_write at once.
      add(INIT, 6'($urandom), rbit(), rbit());
      add(IF, 6'($urandom), rbit(), 1'b1);
      add(ID, SW, rbit(), rbit());
      add(EXE_MEM, SW, rbit(), rbit());
      for (int i = 0; i < 3; i++) add(MEM_WR, SW, rbit(), 1'b0);
      run_plan();
      #1 rst_n = 1'b0;
      #1 check("memwr_async_reset", actual(), zeros);
      @(posedge clk); #1 rst_n = 1'b1;
      add(INIT, 6'($urandom), rbit(), rbit());
      add(IF, 6'($urandom), rbit(), 1'b0);
      run_plan();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the CPU datapath: a Moore-style state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath select and write strobe, including the 3-bit `alu_src_b` select consumed directly by the ALU source-B mux. It also handles the memory `mem_ready` handshake.

## Interface
- No parameters. All encodings are fixed constants in `cpu_ctrl_pkg`.
- clk  in  1  single system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from the cycle after IF completes
- zero  in  1  ALU zero flag, sampled in EXE_BR
- mem_ready  in  1  memory completes the current access this cycle
- state  out  4  current state code (debug)
- pc_write  out  1  PC load strobe
- pc_src  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target
- ir_write  out  1  IR load strobe
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  address source: 0=PC, 1=ALUOut
- reg_write  out  1  register file write strobe
- reg_dst  out  1  destination register: 0=rt, 1=rd
- mem_to_reg  out  1  write-back data: 0=ALUOut, 1=MDR
- alu_src_a  out  1  ALU source A: 0=PC, 1=rs data
- alu_src_b  out  3  ALU source B: 0=rt data, 1=const 4, 2=sign-ext imm, 3=zero-ext imm, 4=sign-ext imm<<2, 5–7 never driven
- alu_op  out  2  0=add, 1=sub, 2=funct decode, 3=or
- illegal  out  1  one-cycle pulse in ID on an unknown opcode
- halted  out  1  high while in HALT

## Operation
- Opcodes: RTYPE 000000, ADDI 001000, ORI 001101, LW 100011, SW 101011, BEQ 000100, J 000010, HALT 111111.
- State codes: INIT 0, IF 1, ID 2, EXE_R 3, EXE_I 4, EXE_MEM 5, EXE_BR 6, EXE_J 7, MEM_RD 8, MEM_WR 9, WB_R 10, WB_I 11, WB_MEM 12, HALT 13.
- INIT: all outputs 0. Goes to IF on the next clock.
- IF: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - ir_write and pc_write equal mem_ready.
  - Stays in IF until mem_ready=1, then goes to ID.
- ID: alu_src_a=0, alu_src_b=4, alu_op=0 (precomputes the branch target). Next state by opcode:
  - RTYPE → EXE_R
  - ADDI/ORI → EXE_I
  - LW/SW → EXE_MEM
  - BEQ → EXE_BR
  - J → EXE_J
  - HALT → HALT
  - other → IF with illegal=1
- EXE_R: a=1, b=0, op=2 → WB_R.
- EXE_I: a=1.
  - ADDI: b=2, op=0.
  - ORI: b=3, op=3.
  - Then → WB_I.
- EXE_MEM: a=1, b=2, op=0. LW → MEM_RD; SW → MEM_WR.
- EXE_BR: a=1, b=0, op=1, pc_src=1, pc_write=zero → IF.
- EXE_J: pc_src=2, pc_write=1 → IF.
- MEM_RD: mem_read=1, iord=1. Waits for mem_ready, then → WB_MEM.
- MEM_WR: mem_write=1, iord=1. Waits for mem_ready, then → IF.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 → IF.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 → IF.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 → IF.
- HALT: halted=1, all strobes 0. Left only by reset.
- Any output not listed for a state is 0.

## Timing
- Reset: state=INIT and all outputs 0 asynchronously while rst_n=0. IF is entered on the first clock edge after reset release.
- Latency with mem_ready constantly 1:
  - R/ADDI/ORI/SW: 4 cycles
  - LW: 5 cycles
  - BEQ/J: 3 cycles
  - Each mem_ready=0 cycle in IF, MEM_RD or MEM_WR adds one cycle.
- Outputs are combinational from state. The only exceptions are ir_write/pc_write in IF (gated by mem_ready) and pc_write in EXE_BR (gated by zero). No output depends on opcode outside ID/EXE_I/EXE_MEM.
- Reset asserted mid-instruction: strobes drop immediately with no partial write. The instruction restarts from INIT.

## Structure
- `cpu_ctrl_pkg`: opcode constants, state codes, alu_src_b and alu_op encodings. The ALU-src-B mux also uses this package.
- One sub-module: `ctrl_decode`, a combinational block mapping state, opcode, zero and mem_ready to all outputs. The top module holds only the state register and next-state logic.

## Test plan
- Reset then release, mem_ready=1, opcode=RTYPE:
  - state sequence 0,1,2,3,10,1.
  - alu_src_b=1 in IF, 4 in ID, 0 in EXE_R.
  - reg_write=1 and reg_dst=1 in WB_R only.
- LW with mem_ready low for 2 cycles in MEM_RD: MEM_RD is held for 3 cycles, then WB_MEM with mem_to_reg=1.
- ORI, then ADDI:
  - EXE_I gives alu_src_b=3, alu_op=3 for ORI.
  - EXE_I gives alu_src_b=2, alu_op=0 for ADDI.
- BEQ:
  - zero=1: pc_write=1, pc_src=1 in EXE_BR.
  - zero=0: pc_write=0.
  - Both cases return to IF after 3 cycles.
- opcode=111110: illegal pulses for 1 cycle in ID, next state is IF. Then HALT: halted=1 is held for 20 cycles, and reset returns to INIT.
- rst_n pulsed low during MEM_WR with mem_ready=0: mem_write drops asynchronously and state=0.
